// File: rtl/layer_seq_ctrl_if.sv
// Start/done handshake bundle between the layer sequencer and its
// three engines (weight loader, compute array, write-back).
interface layer_seq_ctrl_if;
  logic wt_load_start;
  logic wt_load_done;
  logic compute_start;
  logic compute_done;
  logic wb_start;
  logic wb_done;

  modport master (
    output wt_load_start,
    output compute_start,
    output wb_start,
    input  wt_load_done,
    input  compute_done,
    input  wb_done
  );

  modport slave (
    input  wt_load_start,
    input  compute_start,
    input  wb_start,
    output wt_load_done,
    output compute_done,
    output wb_done
  );
endinterface

// File: rtl/layer_seq_ctrl.sv
// CNN layer sequencer: for each layer runs weight load, compute and
// write-back, each phase guarded by a watchdog and by DDR readiness.
module layer_seq_ctrl #(
  parameter int LAYER_NUM   = 8,
  parameter int LAYER_W     = 4,
  parameter int TIMEOUT_CYC = 10_000_000,
  parameter int TO_W        = 24
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               sync_ddr_init_done,
  input  logic               sync_init_cont_sig,
  layer_seq_ctrl_if.master   eng,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               all_done,
  output logic               err_timeout,
  output logic               err_ddr
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WT_START,
    S_WT_WAIT,
    S_CMP_START,
    S_CMP_WAIT,
    S_WB_START,
    S_WB_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [LAYER_W-1:0] IDX_LAST =
    LAYER_W'(LAYER_NUM - 1);
  localparam logic [TO_W-1:0] WD_LAST =
    TO_W'(TIMEOUT_CYC - 1);

  state_t             state;
  state_t             state_n;
  logic [LAYER_W-1:0] idx_n;
  logic [TO_W-1:0]    wdog;
  logic [TO_W-1:0]    wd_n;
  logic               eto_n;
  logic               edd_n;
  logic               waiting;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= S_IDLE;
      layer_idx   <= '0;
      wdog        <= '0;
      err_timeout <= 1'b0;
      err_ddr     <= 1'b0;
    end else begin
      state       <= state_n;
      layer_idx   <= idx_n;
      wdog        <= wd_n;
      err_timeout <= eto_n;
      err_ddr     <= edd_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = layer_idx;
    wd_n    = wdog;
    eto_n   = err_timeout;
    edd_n   = err_ddr;
    waiting = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (sync_init_cont_sig && sync_ddr_init_done) begin
          state_n = S_WT_START;
          idx_n   = '0;
          eto_n   = 1'b0;
          edd_n   = 1'b0;
        end
      end
      S_WT_START: begin
        state_n = S_WT_WAIT;
        wd_n    = '0;
      end
      S_WT_WAIT: begin
        waiting = 1'b1;
        if (eng.wt_load_done) state_n = S_CMP_START;
      end
      S_CMP_START: begin
        state_n = S_CMP_WAIT;
        wd_n    = '0;
      end
      S_CMP_WAIT: begin
        waiting = 1'b1;
        if (eng.compute_done) state_n = S_WB_START;
      end
      S_WB_START: begin
        state_n = S_WB_WAIT;
        wd_n    = '0;
      end
      S_WB_WAIT: begin
        waiting = 1'b1;
        if (eng.wb_done) state_n = S_NEXT;
      end
      S_NEXT: begin
        if (layer_idx == IDX_LAST) begin
          state_n = S_DONE;
        end else begin
          idx_n   = layer_idx + LAYER_W'(1);
          state_n = S_WT_START;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // a done pulse on the terminal-count cycle still advances
    if (waiting && state_n == state) begin
      if (wdog == WD_LAST) begin
        state_n = S_IDLE;
        eto_n   = 1'b1;
      end else begin
        wd_n = wdog + TO_W'(1);
      end
    end

    if (state != S_IDLE && !sync_ddr_init_done) begin
      state_n = S_IDLE;
      edd_n   = 1'b1;
    end
  end

  assign eng.wt_load_start = (state == S_WT_START);
  assign eng.compute_start = (state == S_CMP_START);
  assign eng.wb_start      = (state == S_WB_START);
  assign all_done          = (state == S_DONE);
  assign busy              = (state != S_IDLE);

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Scoreboard bench for layer_seq_ctrl: bench-side engines answer
// start pulses; a monitor checks every emitted pulse against a queue.
module tb_layer_seq_ctrl;
  localparam int LN  = 3;
  localparam int LW  = 4;
  localparam int TO  = 16;
  localparam int TOW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          ddr;
  logic          start;
  logic [LW-1:0] layer_idx;
  logic          busy;
  logic          all_done;
  logic          err_timeout;
  logic          err_ddr;

  layer_seq_ctrl_if eng();

  layer_seq_ctrl #(
    .LAYER_NUM  (LN),
    .LAYER_W    (LW),
    .TIMEOUT_CYC(TO),
    .TO_W       (TOW)
  ) u_dut (
    .sys_clk           (clk),
    .sys_rst           (rst),
    .sync_ddr_init_done(ddr),
    .sync_init_cont_sig(start),
    .eng               (eng),
    .layer_idx         (layer_idx),
    .busy              (busy),
    .all_done          (all_done),
    .err_timeout       (err_timeout),
    .err_ddr           (err_ddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int layer;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  int  force_lat  = -1;
  int  hold_kind  = -1;
  int  hold_layer = -1;
  bit  spur       = 1'b0;

  function automatic void check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endfunction

  // kinds: 0 weight start, 1 compute start, 2 wb start, 3 all_done
  int  mk;
  ev_t me;
  always @(negedge clk) begin
    if (!rst && (eng.wt_load_start || eng.compute_start ||
                 eng.wb_start || all_done)) begin
      if ($countones({eng.wt_load_start, eng.compute_start,
                      eng.wb_start, all_done}) != 1)
        mk = 9;
      else if (eng.wt_load_start) mk = 0;
      else if (eng.compute_start) mk = 1;
      else if (eng.wb_start)      mk = 2;
      else                        mk = 3;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got kind %0d layer %0d, want none",
                 mk, layer_idx);
      end else begin
        me = exp_q.pop_front();
        check("event_kind", mk, me.kind);
        check("event_layer", int'(layer_idx), me.layer);
        check("busy_with_event", int'(busy), 1);
      end
    end
  end

  // engine model: answers each start after a latency, unless held
  int rk, rl, rlat;
  initial begin
    eng.wt_load_done = 1'b0;
    eng.compute_done = 1'b0;
    eng.wb_done      = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (eng.wt_load_start || eng.compute_start ||
                   eng.wb_start)) begin
        rk = eng.wt_load_start ? 0 : (eng.compute_start ? 1 : 2);
        rl = int'(layer_idx);
        if (!(rk == hold_kind && rl == hold_layer)) begin
          rlat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
          @(posedge clk); #1;
          if (spur && rk == 0) begin
            eng.wb_done = 1'b1;
            @(posedge clk); #1;
            eng.wb_done = 1'b0;
          end
          for (int i = 0; i < rlat; i++) begin
            @(posedge clk); #1;
          end
          if (rk == 0) eng.wt_load_done = 1'b1;
          if (rk == 1) eng.compute_done = 1'b1;
          if (rk == 2) eng.wb_done      = 1'b1;
          @(posedge clk); #1;
          eng.wt_load_done = 1'b0;
          eng.compute_done = 1'b0;
          eng.wb_done      = 1'b0;
        end
      end
    end
  end

  // expected pulse order for a run that stops after phase (wk, wl)
  task automatic push_run(int wk, int wl);
    for (int l = 0; l < LN; l++) begin
      for (int k = 0; k < 3; k++) begin
        exp_q.push_back('{kind: k, layer: l});
        if (k == wk && l == wl) return;
      end
    end
    exp_q.push_back('{kind: 3, layer: LN - 1});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic find_start(int kind, int layer, output bit found);
    int n;
    n = 0;
    found = 1'b0;
    while (!found && n < 2000) begin
      @(negedge clk);
      n++;
      found = (int'(layer_idx) == layer) &&
              ((kind == 1 && eng.compute_start) ||
               (kind == 2 && eng.wb_start));
    end
    check("phase_start_seen", int'(found), 1);
  endtask

  task automatic full_run(int lat, bit sp, bit chk_cyc);
    int n;
    bit seen;
    force_lat  = lat;
    spur       = sp;
    hold_kind  = -1;
    hold_layer = -1;
    push_run(-1, -1);
    pulse_start();
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("busy_rise", int'(busy), 1);
        check("errs_cleared", int'({err_timeout, err_ddr}), 0);
      end
      if (sp && n == 5) start = 1'b1;
      if (sp && n == 6) start = 1'b0;
      seen = all_done;
    end
    check("all_done_seen", int'(seen), 1);
    if (chk_cyc) check("run_cycles", n, LN * (3 * lat + 7) + 1);
    @(negedge clk);
    check("busy_after_done", int'(busy), 0);
    check("layer_idx_hold", int'(layer_idx), LN - 1);
    spur = 1'b0;
  endtask

  task automatic timeout_run(int wl);
    bit found;
    int cnt;
    force_lat  = -1;
    hold_kind  = 1;
    hold_layer = wl;
    push_run(1, wl);
    pulse_start();
    find_start(1, wl, found);
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("cmp_wait_cycles", cnt, TO);
    check("err_timeout_set", int'(err_timeout), 1);
    check("err_ddr_clear", int'(err_ddr), 0);
    hold_kind = -1;
  endtask

  task automatic ddr_drop_run();
    bit found;
    hold_kind  = 2;
    hold_layer = 1;
    push_run(2, 1);
    pulse_start();
    find_start(2, 1, found);
    @(negedge clk);
    ddr = 1'b0;
    @(negedge clk);
    check("ddr_abort_busy", int'(busy), 0);
    check("ddr_abort_err", int'(err_ddr), 1);
    check("ddr_abort_eto", int'(err_timeout), 0);
    repeat (10) @(negedge clk);
    ddr = 1'b1;
    hold_kind = -1;
  endtask

  task automatic reset_mid_run();
    bit found;
    int wl;
    wl = int'($urandom_range(0, LN - 1));
    hold_kind  = 1;
    hold_layer = wl;
    push_run(1, wl);
    pulse_start();
    find_start(1, wl, found);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_outputs",
          int'({eng.wt_load_start, eng.compute_start, eng.wb_start,
                busy, all_done, err_timeout, err_ddr}), 0);
    check("rst_layer_idx", int'(layer_idx), 0);
    hold_kind = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no end, want $finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    ddr   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_starts",
          int'({eng.wt_load_start, eng.compute_start, eng.wb_start,
                all_done}), 0);
    check("reset_errs", int'({err_timeout, err_ddr}), 0);
    check("reset_layer_idx", int'(layer_idx), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    full_run(0, 1'b0, 1'b1);
    full_run(-1, 1'b1, 1'b0);

    ddr = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_run_ddr_low", int'(busy), 0);
    end
    ddr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_queued_start", int'(busy), 0);
    end

    timeout_run(int'($urandom_range(0, LN - 1)));
    full_run(TO - 1, 1'b0, 1'b1);
    check("eto_stays_clear", int'(err_timeout), 0);

    ddr_drop_run();
    for (int r = 0; r < 3; r++) full_run(-1, r[0], 1'b0);

    reset_mid_run();
    full_run(-1, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
